stream_fifo: RTL

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO with occupancy count, threshold flags and optional sticky error flags.
// Define STREAM_FIFO_ERR_STICKY_EN to build the sticky overflow/underflow registers; otherwise they read 0.
module stream_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;

    assign empty        = (cnt == '0);
    assign full         = (cnt == CW'(DEPTH));
    assign count        = cnt;
    assign almost_full  = (int'(cnt) >= AF_THRESH);
    assign almost_empty = (int'(cnt) <= AE_THRESH);
    assign rd_data      = mem[rd_ptr];

    // Acceptance is judged on pre-edge flags, so a pop never frees room for a same-cycle push.
    assign push_ok = push && !full && !clr;
    assign pop_ok  = pop && !empty && !clr;

    always_comb begin
        wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr_nxt;
            if (pop_ok)
                rd_ptr <= rd_ptr_nxt;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

`ifdef STREAM_FIFO_ERR_STICKY_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push && full)
                ovf_q <= 1'b1;
            if (pop && empty)
                unf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
